// File: rtl/write_axi256_hls_deadlock_report_unit.sv
// Deadlock report unit for the write_axi256 dataflow region: debounces a detect-unit
// hit, runs one token-trace round from the elected origin and latches a sticky report.
module write_axi256_hls_deadlock_report_unit #(
  parameter int PROC_NUM       = 4,
  parameter int IDX_W          = 2,
  parameter int CONFIRM_CYCLES = 4,
  parameter int TRACE_TIMEOUT  = 64,
  parameter int CNT_W          = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_arrive_vec,
  input  logic                ack,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                dl_active,
  output logic                token_clear,
  output logic                deadlock,
  output logic [IDX_W-1:0]    origin_id,
  output logic [PROC_NUM-1:0] cycle_mask,
  output logic [CNT_W-1:0]    trace_len,
  output logic [CNT_W-1:0]    abort_cnt
);

  typedef enum logic [1:0] {IDLE, CONFIRM, TRACE, REPORT} state_t;

  localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(CONFIRM_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TRACE_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t            state;
  logic [IDX_W-1:0]  cand;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  tcnt;

  logic [IDX_W-1:0]  first_idx;
  logic [IDX_W-1:0]  enter_idx;
  logic              idle_hit;
  logic              confirm_done;
  logic              enter_trace;
  logic              tok_ret;
  logic              tok_timeout;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [PROC_NUM-1:0] onehot(input logic [IDX_W-1:0] idx);
    return PROC_NUM'(1) << idx;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign first_idx    = lowest_idx(dl_detect_vec);
  assign idle_hit     = (state == IDLE) && (|dl_detect_vec);
  assign confirm_done = (state == CONFIRM) && dl_detect_vec[cand] && ((cnt + CNT_ONE) == CONF_LAST);
  assign enter_trace  = (idle_hit && (CONFIRM_CYCLES == 1)) || confirm_done;
  assign enter_idx    = (state == IDLE) ? first_idx : cand;

  // The first TRACE cycle only carries the origin's own token, so a return there is not real.
  assign tok_ret      = (state == TRACE) && (tcnt != CNT_ONE) && token_arrive_vec[origin_id];
  assign tok_timeout  = (state == TRACE) && (tcnt == TO_LAST);
  assign token_clear  = !reset && (tok_ret || tok_timeout);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      tcnt       <= '0;
      origin_vec <= '0;
      dl_active  <= 1'b0;
      deadlock   <= 1'b0;
      origin_id  <= '0;
      cycle_mask <= '0;
      trace_len  <= '0;
      abort_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_hit) begin
            cand  <= first_idx;
            cnt   <= CNT_ONE;
            state <= CONFIRM;
          end
        end
        CONFIRM: begin
          // Only the elected candidate is watched; other detections cannot displace it.
          if (dl_detect_vec[cand]) cnt <= cnt + CNT_ONE;
          else                     state <= IDLE;
        end
        TRACE: begin
          origin_vec <= '0;
          tcnt       <= tcnt + CNT_ONE;
          if (tok_ret) begin
            trace_len  <= tcnt;
            cycle_mask <= cycle_mask | token_arrive_vec;
            deadlock   <= 1'b1;
            state      <= REPORT;
          end else if (tok_timeout) begin
            abort_cnt  <= sat_inc(abort_cnt);
            dl_active  <= 1'b0;
            cycle_mask <= '0;
            state      <= IDLE;
          end else begin
            cycle_mask <= cycle_mask | token_arrive_vec;
          end
        end
        REPORT: begin
          // dl_active stays high here so the detect units keep their dependence state frozen.
          if (ack) begin
            deadlock   <= 1'b0;
            dl_active  <= 1'b0;
            cycle_mask <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (enter_trace) begin
        state      <= TRACE;
        origin_id  <= enter_idx;
        origin_vec <= onehot(enter_idx);
        cycle_mask <= onehot(enter_idx);
        tcnt       <= CNT_ONE;
        dl_active  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_write_axi256_hls_deadlock_report_unit.sv
// Bench for the deadlock report unit: directed vectors, an event-level reference model
// compared every cycle, and literal expectations at the key points of each scenario.
module tb_write_axi256_hls_deadlock_report_unit;

  localparam int P    = 4;
  localparam int CW   = 16;
  localparam int CONF = 4;
  localparam int TO   = 64;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [P-1:0]  det   = '0;
  logic [P-1:0]  arr   = '0;
  logic          ack   = 1'b0;
  logic [P-1:0]  origin_vec;
  logic          dl_active;
  logic          token_clear;
  logic          deadlock;
  logic [1:0]    origin_id;
  logic [P-1:0]  cycle_mask;
  logic [CW-1:0] trace_len;
  logic [CW-1:0] abort_cnt;

  int checks = 0;
  int errors = 0;

  write_axi256_hls_deadlock_report_unit #(
    .PROC_NUM(P), .IDX_W(2), .CONFIRM_CYCLES(CONF), .TRACE_TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .dl_detect_vec(det), .token_arrive_vec(arr), .ack(ack),
    .origin_vec(origin_vec), .dl_active(dl_active), .token_clear(token_clear),
    .deadlock(deadlock), .origin_id(origin_id), .cycle_mask(cycle_mask),
    .trace_len(trace_len), .abort_cnt(abort_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: watched process and how long it has held, age of the running trace
  // (0 = no trace), and whether a report is pending.
  int            m_watch = -1;
  int            m_held  = 0;
  int            m_age   = 0;
  bit            m_rep   = 1'b0;
  logic [P-1:0]  e_ov    = '0;
  logic [P-1:0]  e_mask  = '0;
  logic          e_dl    = 1'b0;
  logic          e_dead  = 1'b0;
  logic          e_tc;
  logic [1:0]    e_oid   = '0;
  logic [CW-1:0] e_len   = '0;
  logic [CW-1:0] e_abort = '0;

  function automatic int lowest(input logic [P-1:0] v);
    for (int i = 0; i < P; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      m_watch = -1; m_held = 0; m_age = 0; m_rep = 1'b0;
      e_ov = '0; e_mask = '0; e_dl = 1'b0; e_dead = 1'b0;
      e_oid = '0; e_len = '0; e_abort = '0;
    end
    e_tc = !reset && (m_age > 0) && ((m_age > 1 && arr[e_oid]) || m_age == TO);
    chk("origin_vec", 32'(origin_vec), 32'(e_ov));
    chk("dl_active", 32'(dl_active), 32'(e_dl));
    chk("token_clear", 32'(token_clear), 32'(e_tc));
    chk("deadlock", 32'(deadlock), 32'(e_dead));
    chk("origin_id", 32'(origin_id), 32'(e_oid));
    chk("cycle_mask", 32'(cycle_mask), 32'(e_mask));
    chk("trace_len", 32'(trace_len), 32'(e_len));
    chk("abort_cnt", 32'(abort_cnt), 32'(e_abort));
    if (!reset) begin
      if (m_age > 0) begin
        e_ov = '0;
        if (m_age > 1 && arr[e_oid]) begin
          e_mask = e_mask | arr; e_len = CW'(m_age); e_dead = 1'b1; m_rep = 1'b1; m_age = 0;
        end else if (m_age == TO) begin
          if (e_abort != '1) e_abort = e_abort + 1'b1;
          e_dl = 1'b0; e_mask = '0; m_age = 0;
        end else begin
          e_mask = e_mask | arr; m_age++;
        end
      end else if (m_rep) begin
        if (ack) begin
          m_rep = 1'b0; e_dead = 1'b0; e_dl = 1'b0; e_mask = '0;
        end
      end else begin
        if (m_watch < 0) begin
          if (det != '0) begin m_watch = lowest(det); m_held = 1; end
        end else if (det[m_watch]) begin
          m_held++;
        end else begin
          m_watch = -1;
        end
        if (m_watch >= 0 && m_held == CONF) begin
          e_oid = 2'(m_watch); e_ov = P'(1) << m_watch; e_mask = e_ov;
          e_dl = 1'b1; m_age = 1; m_watch = -1;
        end
      end
    end
  end

  task automatic cyc(input logic [P-1:0] d, input logic [P-1:0] a, input logic k);
    det = d; arr = a; ack = k;
    @(posedge clock); #1;
  endtask

  task automatic cyc_tc(input logic [P-1:0] d, input logic [P-1:0] a, input logic k,
                        input logic exp_tc);
    det = d; arr = a; ack = k;
    #1 chk("token_clear_lit", 32'(token_clear), 32'(exp_tc));
    @(posedge clock); #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset_deadlock", 32'(deadlock), 32'd0);
    chk("reset_abort", 32'(abort_cnt), 32'd0);

    // Clean detection on process 2
    repeat (CONF) cyc(4'b0100, 4'b0000, 1'b0);
    chk("clean_origin_vec", 32'(origin_vec), 32'h4);
    chk("clean_dl_active", 32'(dl_active), 32'd1);
    cyc(4'b0000, 4'b0000, 1'b0);
    chk("clean_origin_vec_drop", 32'(origin_vec), 32'h0);
    cyc(4'b0000, 4'b1000, 1'b0);
    cyc_tc(4'b0000, 4'b0100, 1'b0, 1'b1);
    chk("clean_deadlock", 32'(deadlock), 32'd1);
    chk("clean_origin_id", 32'(origin_id), 32'd2);
    chk("clean_mask", 32'(cycle_mask), 32'hC);
    chk("clean_len", 32'(trace_len), 32'd3);
    repeat (2) cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1);
    chk("ack_deadlock", 32'(deadlock), 32'd0);
    chk("ack_dl_active", 32'(dl_active), 32'd0);
    chk("ack_mask", 32'(cycle_mask), 32'h0);
    chk("ack_origin_id", 32'(origin_id), 32'd2);
    chk("ack_len", 32'(trace_len), 32'd3);

    // Glitch rejection
    repeat (3) cyc(4'b0001, 4'b0000, 1'b0);
    repeat (6) cyc(4'b0000, 4'b0000, 1'b0);
    chk("glitch_dl_active", 32'(dl_active), 32'd0);
    chk("glitch_origin_vec", 32'(origin_vec), 32'h0);

    // Simultaneous detections, bit 3 dropped mid-confirm, ack during trace ignored
    repeat (2) cyc(4'b1010, 4'b0000, 1'b0);
    repeat (2) cyc(4'b0010, 4'b0000, 1'b0);
    chk("simul_origin_vec", 32'(origin_vec), 32'h2);
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1);
    chk("trace_ack_dl_active", 32'(dl_active), 32'd1);
    cyc_tc(4'b0000, 4'b0010, 1'b0, 1'b1);
    chk("simul_deadlock", 32'(deadlock), 32'd1);
    chk("simul_origin_id", 32'(origin_id), 32'd1);
    chk("simul_mask", 32'(cycle_mask), 32'h2);
    chk("simul_len", 32'(trace_len), 32'd3);
    cyc(4'b0000, 4'b0000, 1'b1);
    chk("simul_ack_deadlock", 32'(deadlock), 32'd0);

    // Timeout: origin arrival in the first trace cycle does not count as a return
    repeat (CONF) cyc(4'b0001, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0001, 1'b0);
    for (int i = 2; i < TO; i++) cyc(4'b0000, (i == 3) ? 4'b0110 : 4'b0000, 1'b0);
    cyc_tc(4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("to_abort", 32'(abort_cnt), 32'd1);
    chk("to_deadlock", 32'(deadlock), 32'd0);
    chk("to_dl_active", 32'(dl_active), 32'd0);
    chk("to_mask", 32'(cycle_mask), 32'h0);
    cyc(4'b0000, 4'b0000, 1'b0);

    // Reset in trace cycle 5
    repeat (CONF) cyc(4'b1000, 4'b0000, 1'b0);
    repeat (4) cyc(4'b0000, 4'b0000, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_dl_active", 32'(dl_active), 32'd0);
    chk("rst_token_clear", 32'(token_clear), 32'd0);
    chk("rst_mask", 32'(cycle_mask), 32'h0);
    chk("rst_origin_id", 32'(origin_id), 32'd0);
    chk("rst_abort", 32'(abort_cnt), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (CONF) cyc(4'b0100, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc_tc(4'b0000, 4'b0100, 1'b0, 1'b1);
    chk("post_rst_deadlock", 32'(deadlock), 32'd1);
    chk("post_rst_origin_id", 32'(origin_id), 32'd2);
    chk("post_rst_mask", 32'(cycle_mask), 32'h4);
    chk("post_rst_len", 32'(trace_len), 32'd2);
    cyc(4'b0000, 4'b0000, 1'b1);
    repeat (2) cyc(4'b0000, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
